// File: rtl/battle_pkg.sv
// Shared types and constants for the battle turn controller: FSM states,
// trainer encoding, datapath widths and the 5-bit LFSR definition.
package battle_pkg;

    localparam int HP_W   = 5;
    localparam int MOVE_W = 2;
    localparam int LFSR_W = 5;

    localparam logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001;
    localparam int                LFSR_TAP_A = 4;
    localparam int                LFSR_TAP_B = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_SEL,
        S_P_ROLL,
        S_P_APPLY,
        S_P_CHECK,
        S_AI_SEL,
        S_AI_ROLL,
        S_AI_APPLY,
        S_AI_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    typedef enum logic {
        PLAYER = 1'b0,
        AI     = 1'b1
    } trainer_t;

    // Shift left, feeding back x^5 + x^3 + 1; maximal length (31), never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/lfsr5.sv
// Free-running 5-bit maximal-length LFSR used for accuracy rolls and AI move choice.
module lfsr5
    import battle_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/battle_turn_ctrl.sv
// Sequences one battle turn (player attack, then AI attack) on a go edge,
// rolling accuracy against the LFSR and pulsing apply_damage to the datapath.
module battle_turn_ctrl
    import battle_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [MOVE_W-1:0] p_move,
    input  logic [HP_W-1:0]   p_hp,
    input  logic [HP_W-1:0]   ai_hp,
    input  logic [HP_W-1:0]   accu,
    output logic [MOVE_W-1:0] move_sel,
    output logic              active_trainer,
    output logic              target,
    output logic              apply_damage,
    output logic              busy,
    output logic              victory,
    output logic              loss,
    output logic              last_hit,
    output logic [7:0]        turn_cnt,
    output state_t            o_dbg_state,
    output logic [LFSR_W-1:0] o_dbg_lfsr
);

    state_t            r_state;
    logic              r_go_q;
    logic              r_armed;
    logic [MOVE_W-1:0] r_move_sel;
    logic              r_active;
    logic              r_last_hit;
    logic [7:0]        r_turn_cnt;

    state_t            w_state_nxt;
    logic [MOVE_W-1:0] w_move_sel_nxt;
    logic              w_active_nxt;
    logic              w_last_hit_nxt;
    logic [7:0]        w_turn_cnt_nxt;
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_start;
    logic              w_hit;

    lfsr5 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (w_lfsr)
    );

    // r_armed stays low for the first edge after reset so a go level held
    // through reset release is absorbed into r_go_q instead of looking like an edge.
    assign w_start = go & ~r_go_q & r_armed;
    assign w_hit   = (w_lfsr != '0) && (w_lfsr <= accu);

    always_comb begin
        w_state_nxt    = r_state;
        w_move_sel_nxt = r_move_sel;
        w_active_nxt   = r_active;
        w_last_hit_nxt = r_last_hit;
        w_turn_cnt_nxt = r_turn_cnt;
        case (r_state)
            S_IDLE: begin
                if (ai_hp == '0) begin
                    w_state_nxt = S_WIN;
                end else if (p_hp == '0) begin
                    w_state_nxt = S_LOSE;
                end else if (w_start) begin
                    w_state_nxt = S_P_SEL;
                end
            end
            S_P_SEL: begin
                w_move_sel_nxt = p_move;
                w_active_nxt   = PLAYER;
                w_state_nxt    = S_P_ROLL;
            end
            S_P_ROLL: begin
                w_last_hit_nxt = w_hit;
                w_state_nxt    = S_P_APPLY;
            end
            S_P_APPLY:  w_state_nxt = S_P_CHECK;
            S_P_CHECK:  w_state_nxt = (ai_hp == '0) ? S_WIN : S_AI_SEL;
            S_AI_SEL: begin
                w_move_sel_nxt = w_lfsr[MOVE_W-1:0];
                w_active_nxt   = AI;
                w_state_nxt    = S_AI_ROLL;
            end
            S_AI_ROLL: begin
                w_last_hit_nxt = w_hit;
                w_state_nxt    = S_AI_APPLY;
            end
            S_AI_APPLY: w_state_nxt = S_AI_CHECK;
            S_AI_CHECK: begin
                if (p_hp == '0) begin
                    w_state_nxt = S_LOSE;
                end else begin
                    if (r_turn_cnt != 8'hFF) begin
                        w_turn_cnt_nxt = r_turn_cnt + 8'd1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            S_WIN:      w_state_nxt = S_WIN;
            S_LOSE:     w_state_nxt = S_LOSE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_go_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_move_sel <= '0;
            r_active   <= PLAYER;
            r_last_hit <= 1'b0;
            r_turn_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_go_q     <= go;
            r_armed    <= 1'b1;
            r_move_sel <= w_move_sel_nxt;
            r_active   <= w_active_nxt;
            r_last_hit <= w_last_hit_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
        end
    end

    // Decoded from state so an asynchronous reset kills the pulse immediately.
    assign apply_damage   = ((r_state == S_P_APPLY) || (r_state == S_AI_APPLY)) && r_last_hit;
    assign busy           = (r_state != S_IDLE) && (r_state != S_WIN) && (r_state != S_LOSE);
    assign victory        = (r_state == S_WIN);
    assign loss           = (r_state == S_LOSE);
    assign move_sel       = r_move_sel;
    assign active_trainer = r_active;
    assign target         = ~r_active;
    assign last_hit       = r_last_hit;
    assign turn_cnt       = r_turn_cnt;
    assign o_dbg_state    = r_state;
    assign o_dbg_lfsr     = w_lfsr;

endmodule
